// File: rtl/l1_mmu_responder.sv
// l1_mmu_responder: responder end of the L1-to-MMU request interface.
// Cached accesses move a 256-bit line as 8 word beats through a 32-bit
// synchronous block RAM (read data arrives the cycle after the address).
// Addresses whose top nibble is 0xF fall in the MMIO window. Those accesses
// go out as single word strobes on the peripheral bus, with a bounded wait.
// All outputs are registered; completion is a one-cycle done pulse.
module l1_mmu_responder #(
    parameter int          MEM_AW        = 13,
    parameter int          MMIO_TIMEOUT  = 255,
    parameter logic [31:0] MMIO_ERR_DATA = 32'hDEADBEEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              l1_mmu_req_read,
    input  logic              l1_mmu_req_write,
    input  logic [31:0]       l1_mmu_req_addr,
    input  logic [255:0]      l1_mmu_write_data,
    output logic              mmu_l1_read_done,
    output logic              mmu_l1_write_done,
    output logic [255:0]      mmu_l1_read_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mmio_addr,
    output logic              mmio_read,
    output logic              mmio_write,
    output logic [31:0]       mmio_wdata,
    input  logic [31:0]       mmio_rdata,
    input  logic              mmio_ready,
    output logic              mmio_timeout
);

    // Wait counter holds 0..MMIO_TIMEOUT-1, one count per strobe cycle.
    localparam int TMO_W = (MMIO_TIMEOUT > 1) ? $clog2(MMIO_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LINE_RD = 3'd1,
        LINE_WR = 3'd2,
        MMIO_RD = 3'd3,
        MMIO_WR = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Shared MMIO window decode: the top address nibble selects peripherals.
    function automatic logic is_mmio_window(input logic [3:0] addr_top);
        return (addr_top == 4'hF);
    endfunction

    // Select word idx of a 256-bit line.
    function automatic logic [31:0] line_word(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'b00000} +: 32];
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               mmio_s;
    logic               tmo_hit_s;
    logic [2:0]         cap_idx_s;
    logic [2:0]         nxt_idx_s;

    logic [3:0]         beat_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [MEM_AW-4:0]  line_base_r;
    logic [255:0]       wdata_r;

    logic               read_done_r;
    logic               write_done_r;
    logic [255:0]       read_data_r;
    logic [MEM_AW-1:0]  mem_addr_r;
    logic               mem_we_r;
    logic [31:0]        mem_wdata_r;
    logic [31:0]        mmio_addr_r;
    logic               mmio_read_r;
    logic               mmio_write_r;
    logic [31:0]        mmio_wdata_r;
    logic               mmio_timeout_r;

    assign mmio_s    = is_mmio_window(l1_mmu_req_addr[31:28]);
    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(MMIO_TIMEOUT - 1));
    // In LINE_RD, beat_cnt_r-1 is the beat whose RAM data is on mem_rdata now.
    assign cap_idx_s = 3'(beat_cnt_r - 4'd1);
    assign nxt_idx_s = beat_cnt_r[2:0] + 3'd1;

    // Next-state decode: accept in IDLE, count beats / wait for the peripheral.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (l1_mmu_req_read) begin
                    accept_s    = 1'b1;
                    state_nxt_s = mmio_s ? MMIO_RD : LINE_RD;
                end else if (l1_mmu_req_write) begin
                    accept_s    = 1'b1;
                    state_nxt_s = mmio_s ? MMIO_WR : LINE_WR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LINE_RD: begin
                if (beat_cnt_r == 4'd8) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LINE_RD;
                end
            end
            LINE_WR: begin
                if (beat_cnt_r == 4'd7) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LINE_WR;
                end
            end
            MMIO_RD, MMIO_WR: begin
                if (mmio_ready || tmo_hit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: request latch, beat sequencing, MMIO wait and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r     <= 4'd0;
            tmo_cnt_r      <= '0;
            line_base_r    <= '0;
            wdata_r        <= 256'd0;
            read_done_r    <= 1'b0;
            write_done_r   <= 1'b0;
            read_data_r    <= 256'd0;
            mem_addr_r     <= '0;
            mem_we_r       <= 1'b0;
            mem_wdata_r    <= 32'd0;
            mmio_addr_r    <= 32'd0;
            mmio_read_r    <= 1'b0;
            mmio_write_r   <= 1'b0;
            mmio_wdata_r   <= 32'd0;
            mmio_timeout_r <= 1'b0;
        end else begin
            read_done_r    <= 1'b0;
            write_done_r   <= 1'b0;
            mmio_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    beat_cnt_r <= 4'd0;
                    tmo_cnt_r  <= '0;
                    if (accept_s) begin
                        line_base_r  <= l1_mmu_req_addr[MEM_AW+1:5];
                        wdata_r      <= l1_mmu_write_data;
                        mem_addr_r   <= {l1_mmu_req_addr[MEM_AW+1:5], 3'b000};
                        mem_wdata_r  <= l1_mmu_write_data[31:0];
                        mem_we_r     <= ~l1_mmu_req_read & ~mmio_s;
                        mmio_addr_r  <= l1_mmu_req_addr & ~32'h0000_0003;
                        mmio_wdata_r <= l1_mmu_write_data[31:0];
                        mmio_read_r  <= l1_mmu_req_read & mmio_s;
                        mmio_write_r <= ~l1_mmu_req_read & mmio_s;
                    end
                end
                LINE_RD: begin
                    // Address beats 0..7 go out one cycle ahead of their data.
                    if (beat_cnt_r < 4'd7) begin
                        mem_addr_r <= {line_base_r, nxt_idx_s};
                    end
                    if (beat_cnt_r != 4'd0) begin
                        read_data_r[{cap_idx_s, 5'b00000} +: 32] <= mem_rdata;
                    end
                    if (beat_cnt_r == 4'd8) begin
                        read_done_r <= 1'b1;
                    end
                    beat_cnt_r <= beat_cnt_r + 4'd1;
                end
                LINE_WR: begin
                    if (beat_cnt_r == 4'd7) begin
                        mem_we_r     <= 1'b0;
                        write_done_r <= 1'b1;
                    end else begin
                        mem_addr_r  <= {line_base_r, nxt_idx_s};
                        mem_wdata_r <= line_word(wdata_r, nxt_idx_s);
                        beat_cnt_r  <= beat_cnt_r + 4'd1;
                    end
                end
                MMIO_RD: begin
                    if (mmio_ready) begin
                        mmio_read_r <= 1'b0;
                        read_data_r <= {224'd0, mmio_rdata};
                        read_done_r <= 1'b1;
                    end else if (tmo_hit_s) begin
                        mmio_read_r    <= 1'b0;
                        read_data_r    <= {224'd0, MMIO_ERR_DATA};
                        read_done_r    <= 1'b1;
                        mmio_timeout_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                MMIO_WR: begin
                    if (mmio_ready) begin
                        mmio_write_r <= 1'b0;
                        write_done_r <= 1'b1;
                    end else if (tmo_hit_s) begin
                        mmio_write_r   <= 1'b0;
                        write_done_r   <= 1'b1;
                        mmio_timeout_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                DONE: begin
                    beat_cnt_r <= 4'd0;
                    tmo_cnt_r  <= '0;
                end
                default: begin
                    beat_cnt_r <= 4'd0;
                    tmo_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign mmu_l1_read_done  = read_done_r;
    assign mmu_l1_write_done = write_done_r;
    assign mmu_l1_read_data  = read_data_r;
    assign mem_addr          = mem_addr_r;
    assign mem_we            = mem_we_r;
    assign mem_wdata         = mem_wdata_r;
    assign mmio_addr         = mmio_addr_r;
    assign mmio_read         = mmio_read_r;
    assign mmio_write        = mmio_write_r;
    assign mmio_wdata        = mmio_wdata_r;
    assign mmio_timeout      = mmio_timeout_r;

endmodule

// File: tb/tb_l1_mmu_responder.sv
// Bench for l1_mmu_responder: behavioural sync RAM, table of line transactions,
// hand-written MMIO, back-to-back and mid-transaction reset sequences.
module tb_l1_mmu_responder;
    localparam int          MEM_AW        = 13;
    localparam int          MMIO_TIMEOUT  = 4;
    localparam logic [31:0] MMIO_ERR_DATA = 32'hDEADBEEF;

    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic              l1_mmu_req_read, l1_mmu_req_write;
    logic [31:0]       l1_mmu_req_addr;
    logic [255:0]      l1_mmu_write_data;
    logic              mmu_l1_read_done, mmu_l1_write_done;
    logic [255:0]      mmu_l1_read_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [31:0]       mmio_addr, mmio_wdata, mmio_rdata;
    logic              mmio_read, mmio_write, mmio_ready, mmio_timeout;

    logic              tb_wr_en;
    logic [MEM_AW-1:0] tb_wr_addr;
    logic [31:0]       tb_wr_data;
    logic [31:0]       ram [0:(1<<MEM_AW)-1];

    int checks = 0;
    int failures = 0;

    l1_mmu_responder #(
        .MEM_AW(MEM_AW), .MMIO_TIMEOUT(MMIO_TIMEOUT), .MMIO_ERR_DATA(MMIO_ERR_DATA)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .l1_mmu_req_read(l1_mmu_req_read), .l1_mmu_req_write(l1_mmu_req_write),
        .l1_mmu_req_addr(l1_mmu_req_addr), .l1_mmu_write_data(l1_mmu_write_data),
        .mmu_l1_read_done(mmu_l1_read_done), .mmu_l1_write_done(mmu_l1_write_done),
        .mmu_l1_read_data(mmu_l1_read_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mmio_addr(mmio_addr), .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
        .mmio_timeout(mmio_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Synchronous RAM: data for an address appears the cycle after it is presented.
    always @(posedge sys_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (tb_wr_en) ram[tb_wr_addr] <= tb_wr_data;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [255:0] mk_line(input logic [31:0] b, input logic [31:0] s);
        logic [255:0] l;
        l = 256'd0;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = b + s * 32'(k);
        return l;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cached line transaction; latency counted from the accepting edge.
    task automatic do_line(input string tag, input vec_t v);
        int c, we_cnt, bad, lat, wrong_done;
        logic [MEM_AW-1:0] base;
        base = MEM_AW'((v.addr >> 2) & 32'h0000_1FF8);
        c = 0; we_cnt = 0; bad = 0; lat = -1; wrong_done = 0;
        @(negedge sys_clk);
        l1_mmu_req_addr = v.addr; l1_mmu_write_data = v.wdata;
        l1_mmu_req_read = ~v.wr;  l1_mmu_req_write = v.wr;
        while (lat < 0 && c < 30) begin
            @(negedge sys_clk);
            c++;
            if (mem_we) we_cnt++;
            if (c <= 8 && mem_addr !== base + MEM_AW'(c - 1)) bad++;
            if (v.wr && c <= 8 && mem_wdata !== v.wdata[32*(c-1) +: 32]) bad++;
            if (v.wr ? mmu_l1_read_done : mmu_l1_write_done) wrong_done++;
            if (v.wr ? mmu_l1_write_done : mmu_l1_read_done) begin
                lat = c;
                l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
            end
        end
        l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
        check({tag, " latency"}, 256'(lat), v.wr ? 256'd9 : 256'd10);
        check({tag, " we_cycles"}, 256'(we_cnt), v.wr ? 256'd8 : 256'd0);
        check({tag, " beat_addr_data"}, 256'(bad), 256'd0);
        check({tag, " wrong_done"}, 256'(wrong_done), 256'd0);
        check({tag, " read_data"}, mmu_l1_read_data, v.exp_rdata);
        @(negedge sys_clk);
        check({tag, " done_single"}, {254'd0, mmu_l1_read_done, mmu_l1_write_done}, 256'd0);
    endtask

    // One MMIO access; ready_at = strobe cycle in which ready is raised (0 = never).
    task automatic do_mmio(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int ready_at, input logic [31:0] rd,
                           input int exp_strobe, input int exp_lat, input logic exp_tmo,
                           input logic [255:0] exp_rdata);
        int c, st_cnt, bad, lat;
        logic tmo_seen, strobe;
        c = 0; st_cnt = 0; bad = 0; lat = -1; tmo_seen = 1'b0;
        @(negedge sys_clk);
        l1_mmu_req_addr = addr; l1_mmu_write_data = {224'd0, wd};
        l1_mmu_req_read = ~wr;  l1_mmu_req_write = wr;
        while (lat < 0 && c < 20) begin
            @(negedge sys_clk);
            c++;
            mmio_ready = 1'b0;
            strobe = wr ? mmio_write : mmio_read;
            if (wr ? mmio_read : mmio_write) bad++;
            if (wr ? mmu_l1_read_done : mmu_l1_write_done) bad++;
            if (strobe) begin
                st_cnt++;
                if (mmio_addr !== (addr & 32'hFFFF_FFFC)) bad++;
                if (wr && mmio_wdata !== wd) bad++;
            end
            if (wr ? mmu_l1_write_done : mmu_l1_read_done) begin
                lat = c;
                tmo_seen = mmio_timeout;
                l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
            end else if (strobe && ready_at != 0 && st_cnt == ready_at) begin
                mmio_ready = 1'b1;
                mmio_rdata = rd;
            end
        end
        l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0; mmio_ready = 1'b0;
        check({tag, " strobe_cycles"}, 256'(st_cnt), 256'(exp_strobe));
        check({tag, " latency"}, 256'(lat), 256'(exp_lat));
        check({tag, " addr_data_type"}, 256'(bad), 256'd0);
        check({tag, " timeout"}, {255'd0, tmo_seen}, {255'd0, exp_tmo});
        check({tag, " read_data"}, mmu_l1_read_data, exp_rdata);
        @(negedge sys_clk);
        check({tag, " idle_after"},
              {251'd0, mmu_l1_read_done, mmu_l1_write_done, mmio_timeout, mmio_read, mmio_write},
              256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l11, la, lb, lc;
        int rd_cnt, wr_cnt, we_cnt, done_seen;
        l11 = mk_line(32'h1111_1111, 32'h1111_1111);
        la  = mk_line(32'hA000_0000, 32'h0000_0001);
        lb  = mk_line(32'hB000_0000, 32'h0000_0001);
        lc  = mk_line(32'hC000_0000, 32'h0000_0003);
        vecs[0] = '{1'b0, 32'h0000_0400, 256'd0, l11};
        vecs[1] = '{1'b1, 32'h0000_0820, la,     l11};  // read data held over a write
        vecs[2] = '{1'b0, 32'h0000_0820, 256'd0, la};
        vecs[3] = '{1'b0, 32'h0000_841F, 256'd0, l11};  // high-bit alias + ignored low bits
        vecs[4] = '{1'b1, 32'h0000_7FE0, lc,     l11};  // last line of the RAM
        vecs[5] = '{1'b0, 32'h0000_7FE0, 256'd0, lc};

        rst_n = 1'b0;
        l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
        l1_mmu_req_addr = 32'd0; l1_mmu_write_data = 256'd0;
        mmio_ready = 1'b0; mmio_rdata = 32'd0;
        tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = 32'd0;

        // Preload words 0x100..0x107 while the DUT is held in reset.
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            tb_wr_en = 1'b1;
            tb_wr_addr = MEM_AW'(32'h100 + k);
            tb_wr_data = 32'h1111_1111 * 32'(k + 1);
        end
        @(negedge sys_clk);
        tb_wr_en = 1'b0;
        check("reset read_data", mmu_l1_read_data, 256'd0);
        check("reset addrs", {192'd0, 19'(mem_addr), mmio_addr}, 256'd0);
        check("reset flags",
              {250'd0, mmu_l1_read_done, mmu_l1_write_done, mem_we, mmio_read, mmio_write, mmio_timeout},
              256'd0);
        check("reset wdata", {192'd0, mem_wdata, mmio_wdata}, 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_line($sformatf("vec%0d", i), vecs[i]);
        for (int k = 0; k < 8; k++)
            check($sformatf("ram 0x%0h", 32'h208 + k), {224'd0, ram[32'h208 + k]}, {224'd0, 32'hA000_0000 + 32'(k)});

        // Read followed by a write-back raised at the read's done negedge.
        rd_cnt = 0; wr_cnt = 0; we_cnt = 0;
        @(negedge sys_clk);
        l1_mmu_req_addr = 32'h0000_0400; l1_mmu_req_read = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            if (mem_we) we_cnt++;
            if (mmu_l1_write_done) begin
                wr_cnt++;
                l1_mmu_req_write = 1'b0;
            end
            if (mmu_l1_read_done) begin
                rd_cnt++;
                l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b1;
                l1_mmu_req_addr = 32'h0000_0820; l1_mmu_write_data = lb;
            end
        end
        l1_mmu_req_read = 1'b0; l1_mmu_req_write = 1'b0;
        check("rdwr read_dones", 256'(rd_cnt), 256'd1);
        check("rdwr write_dones", 256'(wr_cnt), 256'd1);
        check("rdwr we_cycles", 256'(we_cnt), 256'd8);
        check("rdwr read_data", mmu_l1_read_data, l11);
        check("rdwr ram first", {224'd0, ram[32'h208]}, {224'd0, 32'hB000_0000});
        check("rdwr ram last", {224'd0, ram[32'h20F]}, {224'd0, 32'hB000_0007});

        // MMIO accesses: normal, last-cycle ready, and timeouts.
        do_mmio("mmio_rd", 1'b0, 32'hFFFF_FC03, 32'd0, 3, 32'h0000_005A, 3, 4, 1'b0, {224'd0, 32'h5A});
        do_mmio("mmio_wr_tmo", 1'b1, 32'hF000_0010, 32'h1234_5678, 0, 32'd0, 4, 5, 1'b1, {224'd0, 32'h5A});
        do_mmio("mmio_rd_tmo", 1'b0, 32'hF000_0008, 32'd0, 0, 32'd0, 4, 5, 1'b1, {224'd0, MMIO_ERR_DATA});
        do_mmio("mmio_rd_last", 1'b0, 32'hF000_0104, 32'd0, 4, 32'hCAFE_0001, 4, 5, 1'b0, {224'd0, 32'hCAFE_0001});
        do_mmio("mmio_wr_fast", 1'b1, 32'hF000_0020, 32'h0BAD_F00D, 1, 32'd0, 1, 2, 1'b0, {224'd0, 32'hCAFE_0001});

        // Reset during LINE_RD beat 4, then a clean re-read of the same line.
        @(negedge sys_clk);
        l1_mmu_req_addr = 32'h0000_0400; l1_mmu_req_read = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("rst beat4 addr", {243'd0, mem_addr}, {243'd0, 13'h104});
        rst_n = 1'b0;
        #1;
        check("rst mid read_data", mmu_l1_read_data, 256'd0);
        check("rst mid addr", {243'd0, mem_addr}, 256'd0);
        check("rst mid flags", {253'd0, mmu_l1_read_done, mem_we, mmio_read}, 256'd0);
        l1_mmu_req_read = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            if (mmu_l1_read_done || mmu_l1_write_done) done_seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            if (mmu_l1_read_done || mmu_l1_write_done) done_seen++;
        end
        check("rst no_done", 256'(done_seen), 256'd0);
        do_line("post_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_mmu_responder.md
Name: l1_mmu_responder

Overview:
- Responder end of the L1-to-MMU request interface. Serves 256-bit cache-line reads and writes from the L1 cache against a 32-bit-wide synchronous block RAM, in 8 word beats.
- Forwards MMIO word accesses to the peripheral bus with a bounded wait.
- Sits between the L1 cache and main memory/peripherals. Decides MMIO vs. memory using the shared mmio_addr decoder.

Parameters:
- MEM_AW, 13, word-address width of the backing RAM (2^13 words = 32KB).
- MMIO_TIMEOUT, 255, maximum cycles waited for mmio_ready before forced completion.
- MMIO_ERR_DATA, 32'hDEADBEEF, read data returned on MMIO timeout.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset.
- l1_mmu_req_read  in  1  level request: read line (cached) or word (MMIO).
- l1_mmu_req_write  in  1  level request: write line (cached) or word (MMIO).
- l1_mmu_req_addr  in  32  request address; bits [4:0] ignored for line accesses.
- l1_mmu_write_data  in  256  line write data; MMIO writes use [31:0].
- mmu_l1_read_done  out  1  one-cycle completion pulse for reads.
- mmu_l1_write_done  out  1  one-cycle completion pulse for writes.
- mmu_l1_read_data  out  256  line data, or {224'b0, word} for MMIO.
- mem_addr  out  MEM_AW  RAM word address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after mem_addr is presented.
- mmio_addr  out  32  word-aligned MMIO address.
- mmio_read  out  1  MMIO read strobe, held until ready or timeout.
- mmio_write  out  1  MMIO write strobe, held until ready or timeout.
- mmio_wdata  out  32  MMIO write data.
- mmio_rdata  in  32  MMIO read data; valid when mmio_ready=1.
- mmio_ready  in  1  peripheral completion.
- mmio_timeout  out  1  one-cycle pulse, concurrent with done, on forced MMIO completion.

Behaviour:
- Reset: rst_n is asynchronous, active-low. While asserted:
  - all outputs are 0, including mmu_l1_read_data=0, mem_addr=0, mmio_addr=0;
  - state goes to IDLE and the beat/timeout counters clear.
  - Reset mid-transaction abandons it: no done pulse, mem_we drops immediately, partial RAM writes stay.
- States: IDLE, LINE_RD, LINE_WR, MMIO_RD, MMIO_WR, DONE.
- IDLE accept rules:
  - A request is accepted at the posedge on which IDLE samples req_read or req_write high.
  - Read has priority if both are high; no write occurs in that case.
  - Address and write data are latched at accept. Later request/addr changes are ignored until DONE.
- Cached or MMIO is decided from the latched address by mmio_addr.
- LINE_RD (accept in cycle A):
  - Line base = addr[MEM_AW+1:5]. In cycles A+1..A+8, mem_addr = {base, k} for k = 0..7, mem_we=0.
  - Beat k's mem_rdata is captured into mmu_l1_read_data[32k+:32] at the end of cycle A+2+k.
  - DONE in cycle A+10 with mmu_l1_read_data complete.
- LINE_WR:
  - In cycles A+1..A+8, mem_we=1, mem_addr = {base, k}, mem_wdata = write_data[32k+:32].
  - mem_we=0 from A+9. DONE in cycle A+9.
- MMIO_RD / MMIO_WR:
  - From A+1, mmio_read or mmio_write is high, with mmio_addr = {addr[31:2], 2'b00} and mmio_wdata = write_data[31:0].
  - On the first cycle with mmio_ready=1: strobe drops next cycle. A read captures {224'b0, mmio_rdata}. Enter DONE.
  - If ready is not seen within MMIO_TIMEOUT cycles of strobe assertion: complete anyway. A read returns {224'b0, MMIO_ERR_DATA}; mmio_timeout pulses in the DONE cycle.
- DONE:
  - Exactly one cycle. read_done or write_done is high, matching the accepted type.
  - Then IDLE.
  - The L1 samples done on the negedge and drops or changes its request before the next posedge. IDLE therefore never re-accepts the completed request; a new request (e.g. the write-back following a read-then-write miss) is accepted on the posedge right after DONE.
- read_data hold/update:
  - mmu_l1_read_data holds its value after DONE and through write transactions.
  - It is overwritten beat-by-beat only during the next LINE_RD, or in full at MMIO read capture.
- Addresses: bits above MEM_AW+1 are ignored for RAM accesses (aliasing), with no error.
- Only one outstanding transaction; no pipelining across requests.

Test Plan:
- Preload RAM words 0x100..0x107 = 0x11111111*(k+1); req_read addr 0x00000400 -> mem_addr steps 0x100..0x107 over A+1..A+8; read_done single pulse at A+10; read_data[31:0]=0x11111111, [255:224]=0x88888888.
- req_write addr 0x00000820, data word k=0xA0000000+k -> mem_we high exactly 8 cycles, RAM 0x208..0x20F = 0xA0000000..0xA0000007; write_done pulse at A+9; then read back the same line, equal.
- Read-then-write sequence: read 0x400 completes, L1 raises req_write 0x820 at the following negedge -> write accepted on the posedge after DONE; exactly one read_done and one write_done; no duplicate read.
- MMIO read addr 0xFFFFFC03 with ready after 3 cycles, rdata=0x0000005A -> mmio_addr=0xFFFFFC00; mmio_read high 3 cycles; read_data=0x5A with upper bits 0; mmio_timeout=0.
- MMIO write with ready never asserted, MMIO_TIMEOUT=4 -> mmio_write high 4 cycles; write_done and mmio_timeout pulse together; FSM back in IDLE.
- Assert rst_n low during LINE_RD beat 4 -> outputs zero immediately, no done pulse; after release, a fresh read of the same line completes normally in 10 cycles.
